// File: rtl/sample_tx_pkg.sv
// Shared types and constants for the strobed-sample transmitter.
package sample_tx_pkg;

  // Launch FSM states
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStrobe = 2'd1,
    StGap    = 2'd2
  } state_e;

  localparam int unsigned GAP_CNT_W      = 4;
  localparam int unsigned COUNT_W        = 8;
  localparam int unsigned DEF_DATA_W     = 8;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO; pointers carry one extra wrap bit to tell full from empty.
module sample_fifo
  import sample_tx_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PtrOne = (AW + 1)'(1);

  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic              do_push, do_pop;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; reset flushes the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/sample_strobe_tx.sv
// Strobed-sample transmitter: buffers upstream samples and replays each as data_o with a
// one-cycle strobe_o, spaced by GAP_CYCLES idle cycles.
// Optional build macro SAMPLE_TX_PARITY_EN adds parity_o (even parity of data_o).
module sample_strobe_tx
  import sample_tx_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DATA_W-1:0]  data_o,
  output logic               strobe_o,
  output logic               busy_o,
  output logic [COUNT_W-1:0] sent_count
`ifdef SAMPLE_TX_PARITY_EN
  ,
  output logic               parity_o
`endif
);

  localparam bit NoGap = (GAP_CYCLES == 0);
  localparam logic [GAP_CNT_W-1:0] GapInit  = GAP_CNT_W'(NoGap ? 0 : GAP_CYCLES - 1);
  localparam logic [GAP_CNT_W-1:0] GapOne   = GAP_CNT_W'(1);
  localparam logic [COUNT_W-1:0]   CountOne = COUNT_W'(1);

  state_e               state_q, state_d;
  logic [GAP_CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 strobe_q, strobe_d;
  logic [COUNT_W-1:0]   sent_q, sent_d;
  logic [DATA_W-1:0]    fifo_head;
  logic                 fifo_full, fifo_empty;
  logic                 launch;

  sample_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (in_valid),
    .wdata(in_data),
    .pop  (launch),
    .rdata(fifo_head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // A new strobe may start from idle, at the end of the gap, or straight after a strobe
  // when no gap is configured
  assign launch = ena && !fifo_empty &&
                  ((state_q == StIdle) ||
                   ((state_q == StGap) && (gap_cnt_q == '0)) ||
                   ((state_q == StStrobe) && NoGap));

  assign in_ready   = !fifo_full;
  assign data_o     = data_q;
  assign strobe_o   = strobe_q;
  assign sent_count = sent_q;
  assign busy_o     = !fifo_empty || (state_q != StIdle);

  // Next-state, gap countdown and launch side effects
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    data_d    = data_q;
    strobe_d  = 1'b0;
    sent_d    = sent_q;
    unique case (state_q)
      StIdle: begin
        if (launch) state_d = StStrobe;
      end
      StStrobe: begin
        if (launch) begin
          state_d = StStrobe;
        end else if (!NoGap) begin
          state_d   = StGap;
          gap_cnt_d = GapInit;
        end else begin
          state_d = StIdle;
        end
      end
      StGap: begin
        if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - GapOne;
        end else if (launch) begin
          state_d = StStrobe;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (launch) begin
      data_d   = fifo_head;
      strobe_d = 1'b1;
      sent_d   = sent_q + CountOne;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      gap_cnt_q <= '0;
      data_q    <= '0;
      strobe_q  <= 1'b0;
      sent_q    <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      data_q    <= data_d;
      strobe_q  <= strobe_d;
      sent_q    <= sent_d;
    end
  end

`ifdef SAMPLE_TX_PARITY_EN
  logic parity_q;

  // Parity tracks data_o, so it only moves at a launch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else if (launch) begin
      parity_q <= ^fifo_head;
    end
  end

  assign parity_o = parity_q;
`endif

endmodule

// File: tb/tb_sample_strobe_tx.sv
// Self-checking bench for sample_strobe_tx: queue-based reference model on the default
// instance plus directed literal checks, and a second instance built with no gap.
module tb_sample_strobe_tx;

  localparam int DEPTH = 4;
  localparam int GAP   = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, strobe_o, busy_o;
  logic [7:0] data_o, sent_count;
  logic       parity_o;

  logic       g0_valid = 1'b0;
  logic [7:0] g0_data = 8'h00;
  logic       g0_ready, g0_strobe, g0_busy;
  logic [7:0] g0_data_o, g0_sent;
  logic       g0_parity;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sample_strobe_tx #(
    .DATA_W    (8),
    .FIFO_DEPTH(DEPTH),
    .GAP_CYCLES(GAP)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_o    (data_o),
    .strobe_o  (strobe_o),
    .busy_o    (busy_o),
    .sent_count(sent_count)
`ifdef SAMPLE_TX_PARITY_EN
    ,
    .parity_o  (parity_o)
`endif
  );

  sample_strobe_tx #(
    .DATA_W    (8),
    .FIFO_DEPTH(DEPTH),
    .GAP_CYCLES(0)
  ) u_dut_g0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_data   (g0_data),
    .in_valid  (g0_valid),
    .in_ready  (g0_ready),
    .data_o    (g0_data_o),
    .strobe_o  (g0_strobe),
    .busy_o    (g0_busy),
    .sent_count(g0_sent)
`ifdef SAMPLE_TX_PARITY_EN
    ,
    .parity_o  (g0_parity)
`endif
  );

`ifndef SAMPLE_TX_PARITY_EN
  assign parity_o  = 1'b0;
  assign g0_parity = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a launch needs a queued sample, ena, and at least GAP edges since
  // the previous launch; the sample queue is the FIFO contents.
  logic [7:0] mq[$];
  logic [7:0] m_data = 8'h00;
  logic       m_strobe = 1'b0;
  logic [7:0] m_sent = 8'h00;
  int         m_since = 255;
  bit         m_launch, m_push;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_data   = 8'h00;
      m_strobe = 1'b0;
      m_sent   = 8'h00;
      m_since  = 255;
    end else begin
      m_launch = ena && (mq.size() > 0) && (m_since >= GAP);
      m_push   = in_valid && (mq.size() < DEPTH);
      m_strobe = m_launch;
      if (m_launch) begin
        m_data  = mq.pop_front();
        m_sent  = m_sent + 8'd1;
        m_since = 0;
      end else if (m_since < 255) begin
        m_since++;
      end
      if (m_push) mq.push_back(in_data);
    end
  end

  // Compare DUT against model every cycle outside reset
  always @(negedge clk) begin
    if (rst_n) begin
      chk("data_o", data_o, m_data);
      chk("strobe_o", strobe_o, m_strobe);
      chk("in_ready", in_ready, mq.size() < DEPTH);
      chk("busy_o", busy_o, (mq.size() > 0) || (m_since < GAP + 1));
      chk("sent_count", sent_count, m_sent);
`ifdef SAMPLE_TX_PARITY_EN
      chk("parity_o", parity_o, ^m_data);
`endif
    end
  end

  // Present a sample and hold it until accepted; returns at the negedge after acceptance
  task automatic push(input logic [7:0] v);
    int n = 0;
    in_valid = 1'b1;
    in_data  = v;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("push_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 0, 1);
  endtask

  task automatic wait_strobe();
    int n = 0;
    while (!strobe_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("strobe_timeout", 0, 1);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #3;
    chk("rst_data", data_o, 8'h00);
    chk("rst_strobe", strobe_o, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_sent", sent_count, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ena   = 1'b1;

    // Single sample: strobe one edge after acceptance, then one gap cycle
    push(8'h01);
    chk("t1_pre_strobe", strobe_o, 1'b0);
    chk("t1_pre_busy", busy_o, 1'b1);
    @(negedge clk);
    chk("t1_strobe", strobe_o, 1'b1);
    chk("t1_data", data_o, 8'h01);
    chk("t1_sent", sent_count, 8'd1);
    @(negedge clk);
    chk("t1_gap_strobe", strobe_o, 1'b0);
    chk("t1_gap_busy", busy_o, 1'b1);
    @(negedge clk);
    chk("t1_idle_busy", busy_o, 1'b0);
    chk("t1_hold_data", data_o, 8'h01);

    // Back-to-back stream
    for (int i = 1; i <= 4; i++) push(8'(i));
    wait_idle();
    chk("t2_data", data_o, 8'h04);
    chk("t2_sent", sent_count, 8'd5);

    // Fill with ena low, hold the fifth, then release
    ena = 1'b0;
    for (int i = 1; i <= 4; i++) push(8'(8'h10 + i));
    chk("t3_full_ready", in_ready, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h15;
    repeat (3) begin
      @(negedge clk);
      chk("t3_hold_ready", in_ready, 1'b0);
      chk("t3_hold_strobe", strobe_o, 1'b0);
    end
    ena = 1'b1;
    push(8'h15);
    wait_idle();
    chk("t3_data", data_o, 8'h15);
    chk("t3_sent", sent_count, 8'd10);

    // Reset while strobing with samples still queued
    ena = 1'b0;
    for (int i = 1; i <= 4; i++) push(8'(8'hA0 + i));
    ena = 1'b1;
    @(negedge clk);
    wait_strobe();
    chk("t4_strobe_before", strobe_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_strobe", strobe_o, 1'b0);
    chk("t4_rst_busy", busy_o, 1'b0);
    chk("t4_rst_ready", in_ready, 1'b1);
    chk("t4_rst_sent", sent_count, 8'd0);
    chk("t4_rst_data", data_o, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("t4_no_strobe", strobe_o, 1'b0);
    chk("t4_sent_after", sent_count, 8'd0);

    // Zero-gap instance: two consecutive strobe cycles
    g0_valid = 1'b1;
    g0_data  = 8'h00;
    @(negedge clk);
    g0_data = 8'hFF;
    @(negedge clk);
    g0_valid = 1'b0;
    chk("t5_strobe0", g0_strobe, 1'b1);
    chk("t5_data0", g0_data_o, 8'h00);
    @(negedge clk);
    chk("t5_strobe1", g0_strobe, 1'b1);
    chk("t5_data1", g0_data_o, 8'hFF);
    chk("t5_sent", g0_sent, 8'd2);
    @(negedge clk);
    chk("t5_strobe_end", g0_strobe, 1'b0);
    chk("t5_hold_data", g0_data_o, 8'hFF);
    chk("t5_busy", g0_busy, 1'b0);

    // 256 launches wrap the counter; the last two pin parity
    for (int i = 0; i < 254; i++) push(8'(i));
    wait_idle();
    chk("t6_sent_254", sent_count, 8'd254);
    push(8'h01);
    wait_strobe();
    chk("t6_data01", data_o, 8'h01);
`ifdef SAMPLE_TX_PARITY_EN
    chk("t6_par01", parity_o, 1'b1);
`endif
    wait_idle();
    push(8'h03);
    wait_strobe();
    chk("t6_data03", data_o, 8'h03);
`ifdef SAMPLE_TX_PARITY_EN
    chk("t6_par03", parity_o, 1'b0);
`endif
    wait_idle();
    chk("t6_wrap", sent_count, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_strobe_tx.md
Name: sample_strobe_tx

Overview:
Transmit end of the strobed-sample interface consumed by tt_um_moving_average, whose interface is data on ui_in plus a one-cycle strobe on uio_in[0]. The block accepts samples from an upstream producer over valid/ready and buffers them in a small FIFO. It replays each sample as data_o with a single-cycle strobe_o pulse, separated by a programmable idle gap. It sits in front of the averager in the user design, or in the bench as a reusable stimulus driver.

Parameters:
DATA_W, 8, sample width in bits
FIFO_DEPTH, 4, buffered samples (power of two, >=2)
GAP_CYCLES, 1, strobe-low cycles forced between consecutive strobes (0..15)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  launch enable; gates new strobes only
in_data  input  DATA_W  upstream sample
in_valid  input  1  upstream sample valid
in_ready  output  1  FIFO can accept (= not full)
data_o  output  DATA_W  sample presented to the averager (ui_in side)
strobe_o  output  1  one-cycle sample strobe (uio_in[0] side)
busy_o  output  1  FIFO non-empty or state != IDLE
sent_count  output  8  samples strobed since reset

Behaviour:
- Reset (async assert, sync release): data_o=0, strobe_o=0, in_ready=1, busy_o=0, sent_count=0, FIFO empty, state IDLE, gap counter 0.
- Push: on a rising edge with in_valid && in_ready, write in_data. in_ready is derived from the registered full flag only. There is no bypass. When full, in_ready=0 even if a pop occurs in the same cycle.
- FSM states: IDLE, STROBE, GAP.
- Launch condition L = ena && FIFO non-empty && (state==IDLE || (state==GAP && gap_cnt==0) || (state==STROBE && GAP_CYCLES==0)).
- On L: pop the head, data_o<=head, strobe_o<=1, state<=STROBE, sent_count<=sent_count+1 (wraps 255->0).
- STROBE lasts exactly one cycle; strobe_o returns to 0 next edge unless relaunched (GAP_CYCLES==0 only). If GAP_CYCLES>0: state<=GAP, gap_cnt<=GAP_CYCLES-1.
- GAP: decrement gap_cnt. At gap_cnt==0, launch if L, else go to IDLE.
- Back-to-back period is 1+GAP_CYCLES cycles. With the default, that is 1 high, 1 low.
- Latency: a sample accepted at edge k into an empty, idle block gives strobe_o=1 after edge k+1.
- data_o holds the last sent value between strobes. It never changes while strobe_o=0 except at a launch.
- ena low: no new launch. A STROBE/GAP already in progress completes. The FIFO still accepts pushes.
- Simultaneous push and pop (not full): both occur, and occupancy is unchanged.
- Full FIFO: in_ready=0. Upstream must hold in_valid/in_data stable.
- Empty FIFO in IDLE: outputs hold, busy_o=0.
- Reset mid-strobe: strobe_o drops immediately (async). The FIFO is flushed and sent_count cleared.

Optional Feature:
SAMPLE_TX_PARITY_EN
- Defined: adds output parity_o (1 bit), the even parity of the value loaded into data_o. It is registered alongside data_o, reset 0, and updates only at launch.
- Undefined: the port and its logic are absent. Everything else is identical.

Decomposition:
- Package sample_tx_pkg:
  - state enum (IDLE, STROBE, GAP)
  - GAP_CNT_W=4
  - COUNT_W=8
  - default DATA_W and FIFO_DEPTH constants
- Sub-module sample_fifo: synchronous FIFO with DATA_W/FIFO_DEPTH, push/pop, full/empty, pointer width log2(FIFO_DEPTH)+1. The FSM, gap counter and sent_count stay in sample_strobe_tx.

Test Plan:
- Reset then push 0x01 with ena=1 -> strobe_o high one cycle after the following edge, data_o=0x01, sent_count=1, busy_o falls after strobe+gap.
- Push 0x01,0x02,0x03,0x04 back-to-back (GAP_CYCLES=1) -> strobes in alternate cycles, data_o 01,02,03,04, in_ready stays 1, sent_count=4.
- Push 5 samples with ena=0 -> in_ready=0 after the 4th; the 5th is held. Raise ena -> all 5 are strobed in order 1 per 2 cycles.
- Assert rst_n=0 while strobe_o=1 with 3 queued -> strobe_o=0 immediately, FIFO empty, sent_count=0, no strobe after release.
- GAP_CYCLES=0 build, push 0x00,0xFF -> strobe_o high 2 consecutive cycles, data_o 0x00 then 0xFF.
- 256 samples -> sent_count wraps to 0. With SAMPLE_TX_PARITY_EN, parity_o=1 for 0x01 and 0 for 0x03.
